ps2_keyb_rx: RTL

- Host-side receiver for the shield's PS/2 keyboard port: samples the keyboard-driven clock and data lines and deframes 11-bit device-to-host frames.
- Folds E0/F0 prefix bytes into flags and emits one decoded key event per scancode.
- Runs in the 25 MHz domain next to the VGA block; the top level wires ps2_keyb[1] (CLK) and ps2_keyb[0] (DAT) as inputs only, with no host-to-device drive.

---
 rtl/ps2_keyb_rx.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keyb_rx.sv
// ps2_keyb_rx: host-side PS/2 keyboard receiver.
// Synchronises and glitch-filters the keyboard clock and data lines,
// deframes 11-bit device-to-host frames, folds E0/F0 prefixes into flags and
// emits one key event per scancode.
// Optional build macro: PS2_RX_TIMEOUT_EN adds an inactivity timeout that
// abandons a partial frame after TIMEOUT_CYCLES clocks without a clock edge.
`timescale 1ns/1ps
module ps2_keyb_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code,
  output logic       extended,
  output logic       released,
  output logic       valid,
  output logic       frame_err
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Bit 1 carries the PS/2 clock, bit 0 the PS/2 data.
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          filt_q, filt_d;
  logic [1:0][FCW-1:0] fcnt_q, fcnt_d;
  logic                fclk_prev_q;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_err_q, par_err_d;
  logic        byte_ok_q, byte_ok_d;
  logic        ext_pend_q, ext_pend_d;
  logic        rel_pend_q, rel_pend_d;
  logic [7:0]  code_q, code_d;
  logic        ext_q, ext_d;
  logic        rel_q, rel_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;

  logic sample_pt;
  logic dat_f;

  // Two-flop synchronisers, filters and filtered-clock history.
  // NOTE: the synchroniser and filter flops reset to 1, the idle bus level,
  // so leaving reset never looks like a falling clock edge or a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      fcnt_q      <= '0;
      fclk_prev_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, as the hardware does.
      sync1_q     <= {ps2_clk, ps2_dat};
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      fclk_prev_q <= filt_q[1];
    end
  end

  // Filter: flip a line only after FILTER_LEN consecutive differing samples.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
        else                                   fcnt_d[i] = fcnt_q[i] + FCW'(1);
      end
    end
  end

  // The cycle right after the filtered clock falls is the bit sample point.
  assign sample_pt = fclk_prev_q & ~filt_q[1];
  assign dat_f     = filt_q[0];

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Frame FSM, prefix folding and event output.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    byte_ok_d   = 1'b0;
    ext_pend_d  = ext_pend_q;
    rel_pend_d  = rel_pend_q;
    code_d      = code_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    // A byte accepted on the previous cycle is folded or published here.
    if (byte_ok_q) begin
      case (shift_q)
        8'hE0:   ext_pend_d = 1'b1;
        8'hF0:   rel_pend_d = 1'b1;
        default: begin
          code_d     = shift_q;
          ext_d      = ext_pend_q;
          rel_d      = rel_pend_q;
          valid_d    = 1'b1;
          ext_pend_d = 1'b0;
          rel_pend_d = 1'b0;
        end
      endcase
    end

    if (sample_pt) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_f) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d   = {dat_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_err_d = ~(^{shift_q, dat_f});
          state_d   = S_STOP;
        end
        S_STOP: begin
          if (dat_f && !par_err_q) begin
            byte_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            rel_pend_d  = 1'b0;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef PS2_RX_TIMEOUT_EN
    // to_cnt_q counts cycles since the last sample point inside a frame.
    to_cnt_d = '0;
    if (sample_pt) begin
      to_cnt_d = TCW'(1);
    end else if (state_q != S_IDLE) begin
      if (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
        state_d     = S_IDLE;
        frame_err_d = 1'b1;
        ext_pend_d  = 1'b0;
        rel_pend_d  = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + TCW'(1);
      end
    end
`endif
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      byte_ok_q   <= 1'b0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      code_q      <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      byte_ok_q   <= byte_ok_d;
      ext_pend_q  <= ext_pend_d;
      rel_pend_q  <= rel_pend_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef PS2_RX_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign code      = code_q;
  assign extended  = ext_q;
  assign released  = rel_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;

endmodule
